// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-client round-robin arbiter:
// sizes, the FSM state type and a one-hot helper.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Turns a 2-bit client index into its one-hot grant pattern.
  function automatic logic [N_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the clients and the arbiter.
// The master side drives requests and observes grants; the slave side is the arbiter.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, input gnt, input gnt_id, input gnt_valid, input timeout);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output timeout);

endinterface

// File: rtl/rr_arbiter4_prio_enc4.sv
// Combinational 4-to-2 priority encoder; the lowest set index wins.
// valid is low when no input bit is set, and enc is then 0.
module prio_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_in,
  output logic [ID_W-1:0]  enc,
  output logic             valid
);

  // Scan from bit 0 upward and report the first set bit.
  always_comb begin
    enc   = '0;
    valid = 1'b0;
    if (req_in[0]) begin
      enc   = 2'd0;
      valid = 1'b1;
    end else if (req_in[1]) begin
      enc   = 2'd1;
      valid = 1'b1;
    end else if (req_in[2]) begin
      enc   = 2'd2;
      valid = 1'b1;
    end else if (req_in[3]) begin
      enc   = 2'd3;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with registered one-hot and encoded grants.
// A grant is held while its owner keeps requesting, optionally cut off after
// MAX_HOLD cycles (0 = unlimited). Every release advances the priority pointer
// past the released client and is followed by at least one idle cycle.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [3:0]       hold_cnt, hold_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_nxt;
  logic [ID_W-1:0]  id_q, id_nxt;
  logic             valid_q, valid_nxt;
  logic             timeout_q, timeout_nxt;

  logic [N_REQ-1:0] req_rot;
  logic [ID_W-1:0]  enc;
  logic             enc_valid;
  logic [ID_W-1:0]  winner;

  // Rotate requests right by ptr so the encoder's bit 0 is the highest-priority client.
  always_comb begin
    req_rot = bus.req;
    case (ptr)
      2'd0: req_rot = bus.req;
      2'd1: req_rot = {bus.req[0],   bus.req[3:1]};
      2'd2: req_rot = {bus.req[1:0], bus.req[3:2]};
      2'd3: req_rot = {bus.req[2:0], bus.req[3]};
      default: req_rot = bus.req;
    endcase
  end

  prio_enc4 u_prio_enc4 (
    .req_in (req_rot),
    .enc    (enc),
    .valid  (enc_valid)
  );

  // Undo the rotation; 2-bit addition wraps modulo 4.
  assign winner = enc + ptr;

  // Next-state logic: arbitrate in IDLE, watch only the owner's request in GRANT.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt_q;
    id_nxt      = id_q;
    valid_nxt   = valid_q;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = onehot4(winner);
          id_nxt    = winner;
          valid_nxt = 1'b1;
          hold_nxt  = 4'd1;
        end else begin
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.req[id_q]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          ptr_nxt   = id_q + 2'd1;
        end else if (HOLD_EN && (hold_cnt == HOLD_LIM)) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          valid_nxt   = 1'b0;
          ptr_nxt     = id_q + 2'd1;
          timeout_nxt = 1'b1;
        end else if (hold_cnt != 4'hF) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant without a timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_q     <= gnt_nxt;
      id_q      <= id_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (hold limits 3, 0 and 8) share one
// request/reset stimulus and are each compared every cycle against a
// behavioural round-robin model, plus directed constant checks.
module tb_rr_arbiter4;
  import arb_pkg::*;

  localparam int N_DUT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;

  int n_vec = 0;
  int n_miscompare = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  rr_arbiter4_if bus0 ();
  rr_arbiter4_if bus1 ();
  rr_arbiter4_if bus2 ();

  assign bus0.req = req;
  assign bus1.req = req;
  assign bus2.req = req;

  rr_arbiter4 #(.MAX_HOLD(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  rr_arbiter4 #(.MAX_HOLD(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  rr_arbiter4 #(.MAX_HOLD(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  logic [3:0] obs_gnt   [N_DUT];
  logic [1:0] obs_id    [N_DUT];
  logic       obs_valid [N_DUT];
  logic       obs_to    [N_DUT];

  assign obs_gnt[0] = bus0.gnt;  assign obs_id[0] = bus0.gnt_id;
  assign obs_gnt[1] = bus1.gnt;  assign obs_id[1] = bus1.gnt_id;
  assign obs_gnt[2] = bus2.gnt;  assign obs_id[2] = bus2.gnt_id;
  assign obs_valid[0] = bus0.gnt_valid;  assign obs_to[0] = bus0.timeout;
  assign obs_valid[1] = bus1.gnt_valid;  assign obs_to[1] = bus1.timeout;
  assign obs_valid[2] = bus2.gnt_valid;  assign obs_to[2] = bus2.timeout;

  // Reference model state: who owns the resource, for how many cycles, and
  // which client the round-robin scan starts from.
  int m_limit [N_DUT];
  bit m_busy  [N_DUT];
  int m_owner [N_DUT];
  int m_start [N_DUT];
  int m_cycles[N_DUT];
  bit m_to    [N_DUT];

  // Advance every model by one rising edge using the currently applied inputs.
  task automatic modelStep();
    for (int i = 0; i < N_DUT; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_owner[i] = 0; m_start[i] = 0; m_cycles[i] = 0; m_to[i] = 0;
      end else if (!m_busy[i]) begin
        m_to[i] = 0;
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_start[i] + k) % 4;
          if (!m_busy[i] && req[c]) begin
            m_busy[i] = 1; m_owner[i] = c; m_cycles[i] = 1;
          end
        end
      end else begin
        m_to[i] = 0;
        if (!req[m_owner[i]]) begin
          m_busy[i] = 0; m_start[i] = (m_owner[i] + 1) % 4;
        end else if (m_limit[i] != 0 && m_cycles[i] >= m_limit[i]) begin
          m_busy[i] = 0; m_start[i] = (m_owner[i] + 1) % 4; m_to[i] = 1;
        end else begin
          m_cycles[i] = m_cycles[i] + 1;
        end
      end
    end
  endtask

  // Compare every instance's outputs with its model.
  task automatic checkOutput();
    for (int i = 0; i < N_DUT; i++) begin
      logic [3:0] e_gnt;
      logic [1:0] e_id;
      e_gnt = m_busy[i] ? (4'b0001 << m_owner[i]) : 4'b0000;
      e_id  = 2'(m_owner[i]);
      n_vec++;
      assert (obs_gnt[i] === e_gnt) else begin
        n_miscompare++;
        $error("[TB] FAIL dut%0d gnt observed=%b expected=%b", i, obs_gnt[i], e_gnt);
      end
      n_vec++;
      assert (obs_id[i] === e_id) else begin
        n_miscompare++;
        $error("[TB] FAIL dut%0d gnt_id observed=%b expected=%b", i, obs_id[i], e_id);
      end
      n_vec++;
      assert (obs_valid[i] === m_busy[i]) else begin
        n_miscompare++;
        $error("[TB] FAIL dut%0d gnt_valid observed=%b expected=%b", i, obs_valid[i], m_busy[i]);
      end
      n_vec++;
      assert (obs_to[i] === m_to[i]) else begin
        n_miscompare++;
        $error("[TB] FAIL dut%0d timeout observed=%b expected=%b", i, obs_to[i], m_to[i]);
      end
    end
  endtask

  // Directed check of one observed value against a hand-derived constant.
  task automatic checkConst(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscompare++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the edge, step the model at the edge, check just after it.
  task automatic applyStimulus(input logic [3:0] r, input logic rn);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  // Directed test-plan scenarios followed by a randomized run.
  initial begin
    logic [3:0] rnd_req;
    m_limit[0] = 3; m_limit[1] = 0; m_limit[2] = 8;
    for (int i = 0; i < N_DUT; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_start[i] = 0; m_cycles[i] = 0; m_to[i] = 0;
    end
    req   = 4'b0000;
    rst_n = 1'b0;

    // Reset held with all requests up: nothing may be granted.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, 1'b0);
      checkConst("reset_gnt", obs_gnt[0], 4'b0000);
      checkConst("reset_id", {2'b00, obs_id[0]}, 4'd0);
      checkConst("reset_valid", {3'b000, obs_valid[0]}, 4'd0);
    end

    // Rotation with limit 3: three grant cycles then one timeout gap, per client in turn.
    for (int s = 0; s < 20; s++) begin
      applyStimulus(4'b1111, 1'b1);
      if (s % 4 == 3) begin
        checkConst("rot_gap", obs_gnt[0], 4'b0000);
        checkConst("rot_timeout", {3'b000, obs_to[0]}, 4'd1);
      end else begin
        checkConst("rot_gnt", obs_gnt[0], 4'(1 << ((s / 4) % 4)));
        checkConst("rot_timeout", {3'b000, obs_to[0]}, 4'd0);
      end
    end

    // Single client on the limit-8 instance, then pointer-driven pick of client 3.
    applyStimulus(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0100, 1'b1);
      checkConst("single_gnt", obs_gnt[2], 4'b0100);
      checkConst("single_id", {2'b00, obs_id[2]}, 4'd2);
    end
    applyStimulus(4'b0000, 1'b1);
    checkConst("single_release", obs_gnt[2], 4'b0000);
    applyStimulus(4'b1001, 1'b1);
    checkConst("single_ptr3", obs_gnt[2], 4'b1000);

    // Unlimited hold: a 40-cycle grant with no timeout, then scan from client 2.
    applyStimulus(4'b0000, 1'b0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'b0010, 1'b1);
      checkConst("nolimit_gnt", obs_gnt[1], 4'b0010);
      checkConst("nolimit_timeout", {3'b000, obs_to[1]}, 4'd0);
    end
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    checkConst("nolimit_next", obs_gnt[1], 4'b0001);

    // Owner swaps its request to another client in one cycle: gap, then new grant.
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    checkConst("swap_first", obs_gnt[2], 4'b0010);
    applyStimulus(4'b0100, 1'b1);
    checkConst("swap_gap", obs_gnt[2], 4'b0000);
    applyStimulus(4'b0100, 1'b1);
    checkConst("swap_second", obs_gnt[2], 4'b0100);

    // Request drops on the same cycle the limit is reached: normal release.
    applyStimulus(4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkConst("drop_at_limit_gnt", obs_gnt[0], 4'b0000);
    checkConst("drop_at_limit_timeout", {3'b000, obs_to[0]}, 4'd0);

    // Reset in the middle of client 3's grant.
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkConst("midrst_before", obs_gnt[2], 4'b1000);
    applyStimulus(4'b1000, 1'b0);
    checkConst("midrst_gnt", obs_gnt[2], 4'b0000);
    checkConst("midrst_timeout", {3'b000, obs_to[2]}, 4'd0);
    applyStimulus(4'b1111, 1'b1);
    checkConst("midrst_after", obs_gnt[2], 4'b0001);

    // Random requests that mostly persist, with occasional resets.
    rnd_req = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
      applyStimulus(rnd_req, ($urandom_range(0, 39) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as a 4-to-2 encoded select path, between four clients. It issues a one-hot grant and the matching 2-bit encoded grant index. The grant is held while the winning client keeps its request asserted, with an optional forced release after a programmable number of cycles. It sits between the requesting blocks and the shared resource; `gnt_id` drives the resource's select directly.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may stay high. 0 disables forced release. Legal range is 0..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  4  request vector; bit i high means client i wants the resource. A client holds its bit high for as long as it uses the resource.
- `gnt`  out  4  one-hot grant; all zero when no grant is active.
- `gnt_id`  out  2  encoded index of the granted client; holds its last value while `gnt_valid`=0.
- `gnt_valid`  out  1  high exactly when `gnt` is non-zero.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly released by `MAX_HOLD`.

## Operation
- **State.** FSM with 2 states, IDLE and GRANT. Other state is the priority pointer `ptr` (2 bits) and the hold counter `hold_cnt` (4 bits). All outputs are registered.
- **Reset values.** When `rst_n`=0 at a rising edge: state=IDLE, `gnt`=0000, `gnt_id`=00, `gnt_valid`=0, `timeout`=0, `ptr`=00, `hold_cnt`=0. Reset takes priority over every other event, including mid-grant: a grant in progress is dropped with no `timeout` pulse.
- **IDLE, arbitration.**
  - If `req`≠0, the winner is the first set bit scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Next edge: state=GRANT, `gnt`=onehot(winner), `gnt_id`=winner, `gnt_valid`=1, `hold_cnt`=1.
  - If `req`=0, stay in IDLE with outputs 0.
- **GRANT, normal release.**
  - Only `req[gnt_id]` is examined; other request bits are ignored.
  - If `req[gnt_id]`=0, next edge: state=IDLE, `gnt`=0, `gnt_valid`=0, `ptr`=`gnt_id`+1 (mod 4, so 3 wraps to 0).
- **GRANT, forced release.**
  - If `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD` and `req[gnt_id]`=1, next edge: state=IDLE, outputs cleared, `ptr`=`gnt_id`+1, `timeout`=1 for that one cycle.
  - Otherwise, while `req[gnt_id]`=1, `hold_cnt` increments and saturates at 15.
- **Release precedence.** If the request drops on the same cycle the hold limit is reached, the drop takes precedence: normal release, `timeout`=0.
- **Re-requests.** A client released by timeout may keep `req` high. It is then lowest priority for the next arbitration, because `ptr` has advanced past it.
- **Request changes.** Requests rising or falling while another client holds the grant have no effect until the next IDLE cycle.

## Timing
- **Grant latency.** `req` first sampled high at edge k while in IDLE gives `gnt` high from edge k+1.
- **Release latency.** The owner's `req` sampled low at edge n gives `gnt`=0 from edge n+1.
- **Gap between grants.** At least one IDLE cycle separates any two grants, so the earliest next grant is at edge n+2. `gnt` is therefore never non-zero on two different clients in consecutive cycles.
- **Hold limit.** With `MAX_HOLD`=M≠0 and the request held, `gnt` is high for exactly M cycles. `timeout` is high on the first cycle after those M cycles.
- **Output consistency.** `gnt`, `gnt_id` and `gnt_valid` change on the same edge. No combinational path exists from `req` to any output.

## Structure
- **Shared package `arb_pkg`.** Holds:
  - `N_REQ`=4 and `ID_W`=2;
  - the state enum `arb_state_t` (IDLE, GRANT);
  - the function `onehot4(id)`.
- **Sub-module `prio_enc4`.** Combinational 4-to-2 priority encoder, lowest index wins, with a `valid` output.
  - It is applied to `req` rotated right by `ptr`.
  - winner = (encoded + `ptr`) mod 4.
- **Top module.** Holds the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
- **Reset.** `req`=1111 with `rst_n`=0 for 3 cycles → `gnt`=0000, `gnt_id`=00, `gnt_valid`=0 throughout. Release `rst_n` → `gnt`=0001 one cycle after the first edge sampling `rst_n`=1.
- **Rotation.** `MAX_HOLD`=3, `req`=1111 held → grants 0001, 0010, 0100, 1000, 0001. Each lasts 3 cycles, followed by 1 gap cycle with `timeout`=1.
- **Single client.** `req`=0100 for 5 cycles then 0000 → `gnt`=0100 and `gnt_id`=10 for 5 cycles, then 0. Then `req`=1001 → `gnt`=1000, because `ptr`=3.
- **No hold limit.** `MAX_HOLD`=0, `req`=0010 held 40 cycles → `gnt`=0010 for all 40 cycles and `timeout` never asserts. Then `req`=0011 → `gnt`=0001 after the gap, because `ptr`=2 and the scan 2, 3, 0 finds client 0 first.
- **Simultaneous events.** While client 1 is granted, `req` goes from 0010 to 0100 in one cycle → one gap cycle, then `gnt`=0100. Separately, the request drops on the same cycle `hold_cnt`==`MAX_HOLD` → normal release with `timeout`=0.
- **Mid-grant reset.** Client 3 granted, `rst_n`=0 for 1 cycle → `gnt`=0000 the next cycle, `ptr`=0, no `timeout`. With `req`=1111 after reset → `gnt`=0001.
